// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants for the pipeline-buffer family. Holds the
//               default payload width, the payload field layout
//               (ctrl / alu / memdata / rd) and the all-zeros bubble value.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int c_WIDTH       = 73;

    // Payload field offsets
    localparam int c_CTRL_MSB    = 72;
    localparam int c_CTRL_LSB    = 69;
    localparam int c_ALU_MSB     = 68;
    localparam int c_ALU_LSB     = 37;
    localparam int c_MEMDATA_MSB = 36;
    localparam int c_MEMDATA_LSB = 5;
    localparam int c_RD_MSB      = 4;
    localparam int c_RD_LSB      = 0;

    // Value presented on the data bus whenever no instruction is held
    localparam logic [c_WIDTH-1:0] c_BUBBLE = '0;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] memdata;
        logic [4:0]  rd;
    } payload_t;

    function automatic logic [4:0] get_rd(input logic [c_WIDTH-1:0] payload);
        return payload[c_RD_MSB:c_RD_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf_if
// Description : Handshake bundle of one pipeline buffer.
//               Upstream : in_valid, in_ready, in_data
//               Downstream: out_valid, out_ready, out_data
//               Control  : flush (squash), stall_cnt (backpressure counter)
//               slave  = the buffer side, master = the surrounding pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_buf_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int CNT_W = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, stall_cnt
    );

    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, stall_cnt
    );

endinterface
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sat_counter
// Description : Saturating up-counter, updated on the falling clock edge.
//               clk   - clock (falling edge active)
//               rst   - synchronous active-high clear
//               inc   - add one this edge unless already all-ones
//               count - current value
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    output logic      [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    always_ff @(negedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buf
// Description : Valid/ready pipeline buffer with flush and stall counter.
//               All state changes on the falling edge of clk.
//               clk - clock (falling edge active)
//               rst - synchronous active-high reset
//               bus - pipe_stage_buf_if.slave (in_*, out_*, flush, stall_cnt)
//               Build option PIPE_SKID_EN: two entries (main + skid) with
//               in_ready taken from the skid-empty register, breaking the
//               out_ready -> in_ready path. Without it: single entry with
//               combinational in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int CNT_W = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    pipe_stage_buf_if.slave bus
);

    localparam logic [WIDTH-1:0] c_EMPTY = WIDTH'(c_BUBBLE);

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_deliver;
    logic             w_stall;
    logic [CNT_W-1:0] w_stall_cnt;

    assign w_accept  = bus.in_valid && w_in_ready;
    assign w_deliver = r_main_valid && bus.out_ready;
    assign w_stall   = r_main_valid && !bus.out_ready;

`ifdef PIPE_SKID_EN
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    // Only rst/flush gate the registered skid-empty flag; out_ready has no
    // path to in_ready.
    assign w_in_ready = !rst && !bus.flush && !r_skid_valid;

    // The skid entry is only ever occupied while main is occupied, so main
    // always holds the oldest payload and FIFO order is preserved.
    always_ff @(negedge clk) begin
        if (rst || bus.flush) begin
            r_main_valid <= 1'b0;
            r_main_data  <= c_EMPTY;
            r_skid_valid <= 1'b0;
            r_skid_data  <= c_EMPTY;
        end else if (!r_main_valid) begin
            if (w_accept) begin
                r_main_valid <= 1'b1;
                r_main_data  <= bus.in_data;
            end
        end else if (w_deliver) begin
            if (r_skid_valid) begin
                // Skid full implies in_ready was low: no accept this edge.
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
                r_skid_data  <= c_EMPTY;
            end else if (w_accept) begin
                r_main_data  <= bus.in_data;
            end else begin
                r_main_valid <= 1'b0;
                r_main_data  <= c_EMPTY;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= bus.in_data;
        end
    end
`else
    assign w_in_ready = !rst && !bus.flush && (!r_main_valid || bus.out_ready);

    always_ff @(negedge clk) begin
        if (rst || bus.flush) begin
            r_main_valid <= 1'b0;
            r_main_data  <= c_EMPTY;
        end else if (w_accept) begin
            // Covers simultaneous deliver + accept with no bubble.
            r_main_valid <= 1'b1;
            r_main_data  <= bus.in_data;
        end else if (w_deliver) begin
            r_main_valid <= 1'b0;
            r_main_data  <= c_EMPTY;
        end
    end
`endif

    // Counts backpressure cycles; flush deliberately does not clear it.
    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall),
        .count (w_stall_cnt)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_main_valid;
    assign bus.out_data  = r_main_data;
    assign bus.stall_cnt = w_stall_cnt;

endmodule
`default_nettype wire
